// File: rtl/mcu_pkg.sv
// Shared playback-mode encodings used by the playlist controller, song reader and display.
package mcu_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    REPEAT_ALL  = 2'b00,
    REPEAT_ONE  = 2'b01,
    STOP_AT_END = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  // The reserved code falls back to REPEAT_ALL so a corrupted mode self-heals.
  function automatic mode_e next_mode(input mode_e m);
    case (m)
      REPEAT_ALL: return REPEAT_ONE;
      REPEAT_ONE: return STOP_AT_END;
      default:    return REPEAT_ALL;
    endcase
  endfunction

endpackage

// File: rtl/dffr.sv
// Generic register with synchronous active-high reset to a parameterised value.
module dffr #(
  parameter int           W   = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         r,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (r) q <= RST;
    else   q <= d;
  end

endmodule

// File: rtl/wrap_counter.sv
// Up/down counter over 0..MAX with explicit wrap compares; load_zero > inc > dec.
module wrap_counter #(
  parameter int MAX   = 3,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             load_zero,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] w_count_n;

  always_comb begin
    w_count_n = count;
    if (load_zero)
      w_count_n = '0;
    else if (inc)
      w_count_n = (count == MAX_V) ? '0 : count + WIDTH'(1);
    else if (dec)
      w_count_n = (count == '0) ? MAX_V : count - WIDTH'(1);
  end

  dffr #(.W(WIDTH), .RST('0)) u_count (.clk(clk), .r(reset), .d(w_count_n), .q(count));

endmodule

// File: rtl/mcu_playlist.sv
// Playlist controller: song index, play/pause, playback mode, and the player restart pulse.
module mcu_playlist
  import mcu_pkg::*;
#(
  parameter int NUM_SONGS = 4,
  parameter int SONG_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_button,
  input  logic              next_button,
  input  logic              prev_button,
  input  logic              mode_button,
  input  logic              song_done,
  output logic              play,
  output logic              reset_player,
  output logic [SONG_W-1:0] song,
  output logic [MODE_W-1:0] mode
);

  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);

  logic              r_play, r_rp, r_armed;
  logic [MODE_W-1:0] r_mode;
  logic [SONG_W-1:0] w_song;
  logic              w_inc, w_dec, w_load_zero;
  logic              w_play_n, w_rp_n, w_armed_n, w_done_ev;
  logic [MODE_W-1:0] w_mode_n;

  assign w_done_ev = song_done & r_play & r_armed;

  always_comb begin
    w_inc       = 1'b0;
    w_dec       = 1'b0;
    w_load_zero = 1'b0;
    w_play_n    = r_play;
    w_rp_n      = 1'b0;
    w_mode_n    = mode_button ? MODE_W'(next_mode(mode_e'(r_mode))) : r_mode;

    if (next_button) begin
      w_inc  = 1'b1;
      w_rp_n = 1'b1;
    end else if (prev_button) begin
      w_dec  = 1'b1;
      w_rp_n = 1'b1;
    end else if (w_done_ev) begin
      w_rp_n = 1'b1;
      if (mode_e'(r_mode) == REPEAT_ONE) begin
        // replay the same song: only the restart pulse
      end else if (mode_e'(r_mode) == STOP_AT_END && w_song == LAST_SONG) begin
        w_load_zero = 1'b1;
        w_play_n    = 1'b0;
      end else begin
        w_inc = 1'b1;
      end
    end else if (play_button) begin
      w_play_n = ~r_play;
    end

    // Disarm once song_done is consumed; re-arm only after it is seen low.
    if (!song_done)     w_armed_n = 1'b1;
    else if (w_done_ev && !next_button && !prev_button) w_armed_n = 1'b0;
    else                w_armed_n = r_armed;
  end

  wrap_counter #(.MAX(NUM_SONGS - 1), .WIDTH(SONG_W)) u_song (
    .clk(clk), .reset(reset), .inc(w_inc), .dec(w_dec),
    .load_zero(w_load_zero), .count(w_song)
  );

  dffr #(.W(1), .RST(1'b0)) u_play  (.clk(clk), .r(reset), .d(w_play_n),  .q(r_play));
  dffr #(.W(1), .RST(1'b0)) u_rp    (.clk(clk), .r(reset), .d(w_rp_n),    .q(r_rp));
  dffr #(.W(1), .RST(1'b1)) u_armed (.clk(clk), .r(reset), .d(w_armed_n), .q(r_armed));
  dffr #(.W(MODE_W), .RST(MODE_W'(REPEAT_ALL))) u_mode (
    .clk(clk), .r(reset), .d(w_mode_n), .q(r_mode)
  );

  assign play         = r_play;
  assign reset_player = r_rp;
  assign song         = w_song;
  assign mode         = r_mode;

endmodule

// File: tb/tb_mcu_playlist.sv
// Directed bench driving a 3-song and a 4-song playlist with shared stimulus.
module tb_mcu_playlist;

  logic clk = 1'b0;
  logic reset, play_button, next_button, prev_button, mode_button, song_done;

  logic       a_play, a_rp, b_play, b_rp;
  logic [1:0] a_song, b_song, a_mode, b_mode;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mcu_playlist #(.NUM_SONGS(3), .SONG_W(2)) u_a (
    .clk(clk), .reset(reset), .play_button(play_button), .next_button(next_button),
    .prev_button(prev_button), .mode_button(mode_button), .song_done(song_done),
    .play(a_play), .reset_player(a_rp), .song(a_song), .mode(a_mode)
  );

  mcu_playlist #(.NUM_SONGS(4), .SONG_W(2)) u_b (
    .clk(clk), .reset(reset), .play_button(play_button), .next_button(next_button),
    .prev_button(prev_button), .mode_button(mode_button), .song_done(song_done),
    .play(b_play), .reset_player(b_rp), .song(b_song), .mode(b_mode)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // drive one cycle of inputs, then sample 1 time unit after the edge
  task automatic cyc(input logic n, input logic p, input logic d,
                     input logic pl, input logic m, input logic r);
    next_button = n; prev_button = p; song_done = d;
    play_button = pl; mode_button = m; reset = r;
    @(posedge clk);
    #1;
  endtask

  task automatic st(input string tag, input int sa, input int sb,
                    input int pa, input int pb, input int ra, input int rb);
    chk({tag, " a.song"}, 32'(a_song), sa);
    chk({tag, " b.song"}, 32'(b_song), sb);
    chk({tag, " a.play"}, 32'(a_play), pa);
    chk({tag, " b.play"}, 32'(b_play), pb);
    chk({tag, " a.rp"},   32'(a_rp),   ra);
    chk({tag, " b.rp"},   32'(b_rp),   rb);
  endtask

  task automatic md(input string tag, input int m);
    chk({tag, " a.mode"}, 32'(a_mode), m);
    chk({tag, " b.mode"}, 32'(b_mode), m);
  endtask

  initial begin
    int exp_a[4] = '{1, 2, 0, 1};
    int exp_b[4] = '{1, 2, 3, 0};
    int exp_rp[5] = '{1, 0, 0, 0, 0};

    reset = 1'b1; play_button = 0; next_button = 0; prev_button = 0;
    mode_button = 0; song_done = 0;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    st("reset", 0, 0, 0, 0, 0, 0);
    md("reset", 0);

    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      st($sformatf("next%0d", i), exp_a[i], exp_b[i], 0, 0, 1, 1);
    end
    cyc(0, 0, 0, 0, 0, 0);
    st("idle after next", 1, 0, 0, 0, 0, 0);

    cyc(0, 1, 0, 0, 0, 0);
    st("prev1", 0, 3, 0, 0, 1, 1);
    cyc(0, 1, 0, 0, 0, 0);
    st("prev2 wrap", 2, 2, 0, 0, 1, 1);

    cyc(0, 0, 0, 0, 1, 0);
    md("mode->one", 1);
    cyc(0, 0, 0, 1, 0, 0);
    st("play on", 2, 2, 1, 1, 0, 0);

    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0, 0, 0);
      st($sformatf("repeat_one done%0d", i), 2, 2, 1, 1, exp_rp[i], exp_rp[i]);
    end
    cyc(0, 0, 0, 0, 0, 0);
    st("done low", 2, 2, 1, 1, 0, 0);

    cyc(0, 0, 0, 0, 1, 0);
    md("mode->stop", 2);
    cyc(0, 0, 1, 0, 0, 0);
    st("stop_at_end done", 0, 3, 0, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    st("stop last / paused done", 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    st("hold", 0, 0, 0, 0, 0, 0);

    cyc(0, 0, 0, 0, 1, 0);
    md("mode wrap", 0);
    cyc(1, 0, 0, 0, 0, 0);
    st("next to 1", 1, 1, 0, 0, 1, 1);
    cyc(1, 1, 0, 1, 1, 0);
    st("next+prev+play+mode", 2, 2, 0, 0, 1, 1);
    md("next+prev+play+mode", 1);

    cyc(0, 0, 0, 1, 0, 0);
    st("play on again", 2, 2, 1, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    st("done+play", 2, 2, 1, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 0);

    cyc(1, 0, 0, 1, 1, 1);
    st("reset+next", 0, 0, 0, 0, 0, 0);
    md("reset+next", 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
